// File: rtl/uart_echo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_echo_pkg
//  Description : Shared types, constants and pattern helper for the UART
//                echo traffic generator / checker.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_echo_pkg;

    // Run-control states of the checker
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic MODE_INC  = 1'b0;
    localparam logic MODE_LFSR = 1'b1;

    // Feedback taps of the 8-bit Galois LFSR (x^8 + x^4 + x^3 + x^2 + 1)
    localparam logic [7:0] LFSR_TAPS = 8'h1D;

    // Next pattern byte: plain increment, or one Galois LFSR step
    function automatic logic [7:0] next_pattern(input logic [7:0] cur, input logic mode);
        if (mode == MODE_LFSR) begin
            return {cur[6:0], 1'b0} ^ (cur[7] ? LFSR_TAPS : 8'h00);
        end
        return cur + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/echo_expect_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : echo_expect_fifo
//  Description : Synchronous FIFO holding the bytes sent but not yet echoed.
//                A pop on an empty FIFO is ignored; push and pop together
//                are accepted when full, leaving occupancy unchanged.
//  Revision    : 1.0 - initial release
// ============================================================================
module echo_expect_fifo
    import uart_echo_pkg::*;
#(
    parameter int Width = 8,
    parameter int Depth = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic [Width-1:0]           i_din,
    input  logic                       i_pop,
    output logic [Width-1:0]           o_dout,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(Depth):0]     o_count
);

    localparam int AW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CW = $clog2(Depth) + 1;
    localparam logic [AW-1:0] LAST_PTR = AW'(Depth - 1);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign o_empty = (count_q == '0);
    assign o_full  = (count_q == CW'(Depth));
    assign o_count = count_q;
    assign o_dout  = mem_q[rd_ptr_q];
    assign do_pop  = i_pop && !o_empty;
    assign do_push = i_push && (!o_full || do_pop);

    // Pointer, occupancy and storage update; flush overrides everything
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = i_din;
                wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_echo_checker.sv
`default_nettype none
// ============================================================================
//  Module      : uart_echo_checker
//  Description : Sends a byte pattern into a UART transmit handshake, keeps
//                up to Depth bytes in flight and checks every echoed byte.
//                Reports pass/fail, error count, first error and timeout.
//                ClockFreq only documents the meaning of TimeoutCycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_echo_checker
    import uart_echo_pkg::*;
#(
    parameter int         ClockFreq     = 50_000_000,
    parameter int         NumBytes      = 16,
    parameter int         Depth         = 4,
    parameter logic [7:0] SeedByte      = 8'h7a,
    parameter int         Mode          = 0,
    parameter int         TimeoutCycles = 200_000
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    output logic        Busy,
    output logic        Done,
    output logic        Pass,
    output logic        Timeout,
    output logic [15:0] ErrorCount,
    output logic [15:0] FirstErrIndex,
    output logic [7:0]  FirstErrGot,
    output logic [7:0]  FirstErrExp,
    output logic [7:0]  TxData,
    output logic        TxValid,
    input  logic        TxReady,
    input  logic [7:0]  RxData,
    input  logic        RxValid,
    output logic        RxReady
);

    localparam int CW = $clog2(Depth) + 1;
    localparam int TW = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;
    localparam logic [15:0]   NUM_BYTES = 16'(NumBytes);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TimeoutCycles - 1);
    localparam logic          MODE_SEL  = (Mode == 1) ? MODE_LFSR : MODE_INC;
    // An all-zero LFSR state would lock up, so a zero seed becomes 8'h01
    localparam logic [7:0]    SEED_EFF  = ((SeedByte == 8'h00) && (Mode == 1)) ? 8'h01 : SeedByte;

    generate
        if (ClockFreq < 1 || NumBytes < 1 || NumBytes > 65535 || Depth < 1 || Depth > 16 ||
            ((Depth & (Depth - 1)) != 0) || TimeoutCycles < 2) begin : g_bad_params
            $error("uart_echo_checker: illegal parameter set");
        end
    endgenerate

    state_t        state_q, state_d;
    logic [15:0]   sent_q, sent_d;
    logic [15:0]   rx_idx_q, rx_idx_d;
    logic [7:0]    pattern_q, pattern_d;
    logic [15:0]   err_cnt_q, err_cnt_d;
    logic [15:0]   first_idx_q, first_idx_d;
    logic [7:0]    first_got_q, first_got_d;
    logic [7:0]    first_exp_q, first_exp_d;
    logic          timeout_q, timeout_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

    logic          busy, tx_valid, tx_hs, rx_hs;
    logic          fifo_pop, fifo_flush, fifo_full, fifo_empty;
    logic [7:0]    fifo_dout;
    logic [CW-1:0] fifo_count;
    logic          mismatch, unexpected, tmo_hit;

    echo_expect_fifo #(
        .Width (8),
        .Depth (Depth)
    ) u_fifo (
        .clk     (Clock),
        .rst     (Reset),
        .i_flush (fifo_flush),
        .i_push  (tx_hs),
        .i_din   (pattern_q),
        .i_pop   (fifo_pop),
        .o_dout  (fifo_dout),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_count (fifo_count)
    );

    // Handshake qualifiers; a full FIFO means Depth bytes are outstanding
    always_comb begin
        busy       = (state_q == RUN) || (state_q == DRAIN);
        tx_valid   = (state_q == RUN) && (sent_q < NUM_BYTES) && !fifo_full;
        tx_hs      = tx_valid && TxReady;
        rx_hs      = busy && RxValid;
        fifo_pop   = rx_hs && !fifo_empty;
        mismatch   = fifo_pop && (RxData != fifo_dout);
        unexpected = rx_hs && fifo_empty;
        tmo_hit    = busy && !rx_hs && !fifo_empty && (tmo_cnt_q == TMO_LAST);
    end

    // Next-state, counters, error capture and FIFO flush control
    always_comb begin
        state_d     = state_q;
        sent_d      = sent_q;
        rx_idx_d    = rx_idx_q;
        pattern_d   = pattern_q;
        err_cnt_d   = err_cnt_q;
        first_idx_d = first_idx_q;
        first_got_d = first_got_q;
        first_exp_d = first_exp_q;
        timeout_d   = timeout_q;
        done_d      = done_q;
        pass_d      = pass_q;
        tmo_cnt_d   = tmo_cnt_q;
        fifo_flush  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (Start) begin
                    state_d     = RUN;
                    sent_d      = '0;
                    rx_idx_d    = '0;
                    pattern_d   = SEED_EFF;
                    err_cnt_d   = '0;
                    first_idx_d = '0;
                    first_got_d = '0;
                    first_exp_d = '0;
                    timeout_d   = 1'b0;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    tmo_cnt_d   = '0;
                    fifo_flush  = 1'b1;
                end
            end
            default: begin
                if (tx_hs) begin
                    pattern_d = next_pattern(pattern_q, MODE_SEL);
                    sent_d    = sent_q + 16'd1;
                end
                if (rx_hs) begin
                    rx_idx_d = rx_idx_q + 16'd1;
                end
                if (mismatch || unexpected) begin
                    if (err_cnt_q != 16'hFFFF) begin
                        err_cnt_d = err_cnt_q + 16'd1;
                    end
                    // Count is zero only before the first error of the run
                    if (err_cnt_q == 16'h0000) begin
                        first_idx_d = rx_idx_q;
                        first_got_d = RxData;
                        first_exp_d = unexpected ? 8'h00 : fifo_dout;
                    end
                end
                if (rx_hs || fifo_empty) begin
                    tmo_cnt_d = '0;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
                if (tmo_hit) begin
                    state_d    = DONE;
                    timeout_d  = 1'b1;
                    done_d     = 1'b1;
                    pass_d     = 1'b0;
                    tmo_cnt_d  = '0;
                    fifo_flush = 1'b1;
                end else if (state_q == RUN) begin
                    if (sent_q == NUM_BYTES) begin
                        state_d = DRAIN;
                    end
                end else if (fifo_count == '0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    pass_d  = (err_cnt_d == 16'h0000);
                end
            end
        endcase
    end

    // State registers
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= IDLE;
            sent_q      <= '0;
            rx_idx_q    <= '0;
            pattern_q   <= '0;
            err_cnt_q   <= '0;
            first_idx_q <= '0;
            first_got_q <= '0;
            first_exp_q <= '0;
            timeout_q   <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            tmo_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            sent_q      <= sent_d;
            rx_idx_q    <= rx_idx_d;
            pattern_q   <= pattern_d;
            err_cnt_q   <= err_cnt_d;
            first_idx_q <= first_idx_d;
            first_got_q <= first_got_d;
            first_exp_q <= first_exp_d;
            timeout_q   <= timeout_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            tmo_cnt_q   <= tmo_cnt_d;
        end
    end

    assign Busy          = busy;
    assign Done          = done_q;
    assign Pass          = pass_q;
    assign Timeout       = timeout_q;
    assign ErrorCount    = err_cnt_q;
    assign FirstErrIndex = first_idx_q;
    assign FirstErrGot   = first_got_q;
    assign FirstErrExp   = first_exp_q;
    assign TxData        = pattern_q;
    assign TxValid       = tx_valid;
    assign RxReady       = busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_echo_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_echo_checker
//  Description : Self-checking bench for uart_echo_checker with a queue-based
//                UART loopback model (optional corruption, withholding and
//                random stalls) and a second instance running the LFSR mode.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_echo_checker;

    localparam int         NB   = 16;
    localparam int         DEP  = 4;
    localparam int         TMO  = 100;
    localparam logic [7:0] SEED = 8'h7a;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy, done, pass, timeout;
    logic [15:0] err_cnt, fe_idx;
    logic [7:0]  fe_got, fe_exp;
    logic [7:0]  tx_data, rx_data;
    logic        tx_valid, tx_ready, rx_valid, rx_ready;

    logic        l_busy, l_done, l_pass, l_timeout;
    logic [15:0] l_err_cnt, l_fe_idx;
    logic [7:0]  l_fe_got, l_fe_exp;
    logic [7:0]  l_tx_data, l_rx_data;
    logic        l_tx_valid, l_tx_ready, l_rx_valid, l_rx_ready;

    always #5 clk = ~clk;

    uart_echo_checker #(
        .ClockFreq(50_000_000), .NumBytes(NB), .Depth(DEP),
        .SeedByte(SEED), .Mode(0), .TimeoutCycles(TMO)
    ) dut (
        .Clock(clk), .Reset(rst), .Start(start), .Busy(busy), .Done(done),
        .Pass(pass), .Timeout(timeout), .ErrorCount(err_cnt),
        .FirstErrIndex(fe_idx), .FirstErrGot(fe_got), .FirstErrExp(fe_exp),
        .TxData(tx_data), .TxValid(tx_valid), .TxReady(tx_ready),
        .RxData(rx_data), .RxValid(rx_valid), .RxReady(rx_ready)
    );

    uart_echo_checker #(
        .ClockFreq(50_000_000), .NumBytes(4), .Depth(2),
        .SeedByte(SEED), .Mode(1), .TimeoutCycles(TMO)
    ) dut_lfsr (
        .Clock(clk), .Reset(rst), .Start(start), .Busy(l_busy), .Done(l_done),
        .Pass(l_pass), .Timeout(l_timeout), .ErrorCount(l_err_cnt),
        .FirstErrIndex(l_fe_idx), .FirstErrGot(l_fe_got), .FirstErrExp(l_fe_exp),
        .TxData(l_tx_data), .TxValid(l_tx_valid), .TxReady(l_tx_ready),
        .RxData(l_rx_data), .RxValid(l_rx_valid), .RxReady(l_rx_ready)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Loopback model configuration and observations
    int         cfg_corrupt_idx = -1;
    logic [7:0] cfg_corrupt_val = 8'h00;
    logic       cfg_withhold    = 1'b0;
    logic       cfg_stall       = 1'b0;
    logic [7:0] echo_q[$];
    logic [7:0] tx_log[$];
    logic [7:0] l_log[$];
    int         echo_idx    = 0;
    int         outstanding = 0;
    int         max_occ     = 0;
    int         stall_viol  = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference pattern: n-th byte is seed+n, or seed multiplied by x^n in GF(2^8)/0x11D
    function automatic logic [7:0] model_byte(input int idx, input int mode, input logic [7:0] seed);
        logic [8:0] v;
        if (mode == 0) return 8'((int'(seed) + idx) % 256);
        v = {1'b0, (seed == 8'h00) ? 8'h01 : seed};
        for (int k = 0; k < idx; k++) begin
            v = v << 1;
            if (v[8]) v = v ^ 9'h11D;
        end
        return v[7:0];
    endfunction

    // Loopback model for the main instance
    initial begin
        logic       s_tx_hs, s_rx_hs, s_rst, prev_stall;
        logic [7:0] prev_data;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        prev_stall = 1'b0; prev_data = 8'h00;
        forever begin
            @(negedge clk);
            s_tx_hs = tx_valid && tx_ready;
            s_rx_hs = rx_valid && rx_ready;
            s_rst   = rst;
            if (prev_stall && !(tx_valid && tx_data == prev_data)) stall_viol++;
            prev_stall = tx_valid && !tx_ready && !rst;
            prev_data  = tx_data;
            if (s_rx_hs && outstanding > 0) outstanding--;
            if (s_tx_hs) begin
                echo_q.push_back(tx_data);
                tx_log.push_back(tx_data);
                outstanding++;
            end
            if (outstanding > max_occ) max_occ = outstanding;
            @(posedge clk); #1;
            if (s_rx_hs) rx_valid = 1'b0;
            if (s_rst) begin
                echo_q.delete();
                rx_valid    = 1'b0;
                outstanding = 0;
            end
            tx_ready = cfg_stall ? ~tx_ready : 1'b1;
            if (!rx_valid && echo_q.size() > 0 && !cfg_withhold &&
                (!cfg_stall || $urandom_range(0, 2) != 0)) begin
                rx_data = echo_q.pop_front();
                if (echo_idx == cfg_corrupt_idx) rx_data = cfg_corrupt_val;
                echo_idx++;
                rx_valid = 1'b1;
            end
        end
    end

    // Ideal one-cycle loopback for the LFSR instance
    initial begin
        logic       ls_tx, ls_rx, ls_rst;
        logic [7:0] ls_d;
        l_tx_ready = 1'b1; l_rx_valid = 1'b0; l_rx_data = 8'h00;
        forever begin
            @(negedge clk);
            ls_tx  = l_tx_valid && l_tx_ready;
            ls_rx  = l_rx_valid && l_rx_ready;
            ls_rst = rst;
            ls_d   = l_tx_data;
            if (ls_tx) l_log.push_back(l_tx_data);
            @(posedge clk); #1;
            if (ls_rx || ls_rst) l_rx_valid = 1'b0;
            if (ls_tx && !ls_rst) begin
                l_rx_valid = 1'b1;
                l_rx_data  = ls_d;
            end
        end
    end

    task automatic start_run(input int cidx, input logic [7:0] cval, input logic withhold, input logic stall);
        @(posedge clk); #1;
        cfg_corrupt_idx = cidx;
        cfg_corrupt_val = cval;
        cfg_withhold    = withhold;
        cfg_stall       = stall;
        echo_q.delete();
        tx_log.delete();
        l_log.delete();
        echo_idx    = 0;
        outstanding = 0;
        max_occ     = 0;
        stall_viol  = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        int c = 0;
        while (!done && c < limit) begin
            @(negedge clk);
            c++;
        end
        check_value({tag, "_done"}, done, 1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_value({tag, "_busy"},    busy, 0);
        check_value({tag, "_done"},    done, 0);
        check_value({tag, "_pass"},    pass, 0);
        check_value({tag, "_timeout"}, timeout, 0);
        check_value({tag, "_errcnt"},  err_cnt, 0);
        check_value({tag, "_firsterr"}, {fe_idx, fe_got, fe_exp}, 0);
        check_value({tag, "_txdata"},  tx_data, 0);
        check_value({tag, "_txvalid"}, tx_valid, 0);
        check_value({tag, "_rxready"}, rx_ready, 0);
    endtask

    task automatic check_sequence(input string tag, input int n);
        int bad = 0;
        check_value({tag, "_count"}, tx_log.size(), n);
        for (int i = 0; i < n && i < tx_log.size(); i++)
            if (tx_log[i] !== model_byte(i, 0, SEED)) bad++;
        check_value({tag, "_bytes_wrong"}, bad, 0);
    endtask

    // Test sequence
    initial begin
        int         exp_err, exp_idx, c, n;
        logic [7:0] exp_got, exp_exp, got_b;
        rst = 1'b1; start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst = 1'b0;

        // 1: ideal loopback, incrementing pattern; LFSR instance runs alongside
        start_run(-1, 8'h00, 1'b0, 1'b0);
        wait_done("t1", 500);
        check_value("t1_pass", pass, 1);
        check_value("t1_errcnt", err_cnt, 0);
        check_value("t1_timeout", timeout, 0);
        check_value("t1_busy", busy, 0);
        check_value("t1_count", tx_log.size(), NB);
        for (int i = 0; i < NB; i++)
            check_value($sformatf("t1_tx%0d", i), tx_log[i], model_byte(i, 0, SEED));
        check_value("t3_lfsr_done", l_done, 1);
        check_value("t3_lfsr_pass", l_pass, 1);
        check_value("t3_lfsr_count", l_log.size(), 4);
        for (int i = 0; i < 4; i++)
            check_value($sformatf("t3_lfsr_tx%0d", i), l_log[i], model_byte(i, 1, SEED));

        // 2: byte index 3 corrupted to 8'h00
        start_run(3, 8'h00, 1'b0, 1'b0);
        wait_done("t2", 500);
        exp_err = 0; exp_idx = 0; exp_got = 8'h00; exp_exp = 8'h00;
        for (int i = 0; i < NB; i++) begin
            got_b = (i == 3) ? 8'h00 : model_byte(i, 0, SEED);
            if (got_b != model_byte(i, 0, SEED)) begin
                if (exp_err == 0) begin
                    exp_idx = i; exp_got = got_b; exp_exp = model_byte(i, 0, SEED);
                end
                exp_err++;
            end
        end
        check_value("t2_errcnt", err_cnt, exp_err);
        check_value("t2_first_idx", fe_idx, exp_idx);
        check_value("t2_first_got", fe_got, exp_got);
        check_value("t2_first_exp", fe_exp, exp_exp);
        check_value("t2_pass", pass, 0);
        check_value("t2_timeout", timeout, 0);

        // 4: echoes withheld -> Depth bytes sent, then timeout
        start_run(-1, 8'h00, 1'b1, 1'b0);
        wait_done("t4", 10 * TMO);
        check_value("t4_tx_count", tx_log.size(), DEP);
        check_value("t4_timeout", timeout, 1);
        check_value("t4_pass", pass, 0);
        check_value("t4_busy", busy, 0);

        // 5: TxReady toggling, random echo bursts with concurrent push/pop
        start_run(-1, 8'h00, 1'b0, 1'b1);
        wait_done("t5", 2000);
        check_value("t5_pass", pass, 1);
        check_value("t5_errcnt", err_cnt, 0);
        check_value("t5_occ_within_depth", (max_occ <= DEP), 1);
        check_value("t5_tx_stall_violations", stall_viol, 0);
        check_sequence("t5_seq", NB);

        // 6: reset pulse during byte 5, then a clean rerun
        start_run(-1, 8'h00, 1'b0, 1'b0);
        c = 0;
        while (tx_log.size() < 5 && c < 200) begin
            @(negedge clk);
            c++;
        end
        check_value("t6_reached_byte5", (tx_log.size() >= 5), 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_outputs_zero("t6_after_reset");
        n = tx_log.size();
        repeat (10) @(negedge clk);
        check_value("t6_no_tx_after_reset", tx_log.size(), n);
        start_run(-1, 8'h00, 1'b0, 1'b0);
        wait_done("t6_rerun", 500);
        check_value("t6_rerun_pass", pass, 1);
        check_value("t6_rerun_errcnt", err_cnt, 0);
        check_sequence("t6_rerun_seq", NB);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global time bound
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/uart_echo_checker.md
Name: uart_echo_checker

Overview:
- Synthesizable traffic generator and checker for UART echo paths. It is the in-fabric successor to the single-byte echo bench.
- Sends NumBytes pattern bytes into the UART transmit-side ready/valid interface and keeps up to Depth bytes in flight.
- Compares each echoed byte against an expected-byte FIFO, then reports pass/fail, error count, first-error detail and timeout.
- Sits beside the UART on the FPGA top level or in a bench; connects directly to the UART DataIn/DataOut handshake ports.

Parameters:
- ClockFreq, 50_000_000, clock frequency in Hz; informational, used only to document TimeoutCycles.
- NumBytes, 16, bytes per run; legal range 1..65535.
- Depth, 4, maximum outstanding (sent, not yet echoed) bytes; power of two, 1..16.
- SeedByte, 8'h7a, first pattern byte.
- Mode, 0, pattern mode: 0 = incrementing, 1 = Galois LFSR.
- TimeoutCycles, 200_000, idle cycles without an echo, while bytes are outstanding, before the run aborts.

Ports:
- Clock  in  1  system clock
- Reset  in  1  synchronous, active-high
- Start  in  1  one-cycle pulse; begins a run when in IDLE or DONE
- Busy  out  1  high in RUN and DRAIN
- Done  out  1  high in DONE until the next Start or Reset
- Pass  out  1  valid when Done: ErrorCount==0 and !Timeout
- Timeout  out  1  run aborted by timeout
- ErrorCount  out  16  mismatches plus unexpected bytes; saturates at 16'hFFFF
- FirstErrIndex  out  16  index of the first mismatching byte
- FirstErrGot  out  8  received byte at the first error
- FirstErrExp  out  8  expected byte at the first error
- TxData  out  8  to UART DataIn
- TxValid  out  1  to UART DataInValid
- TxReady  in  1  from UART DataInReady
- RxData  in  8  from UART DataOut
- RxValid  in  1  from UART DataOutValid
- RxReady  out  1  to UART DataOutReady

Behaviour:
- Reset:
  - All outputs are 0.
  - State goes to IDLE; counters and FIFO are cleared.
  - Reset mid-run aborts immediately; no further Tx handshakes occur.
- Handshake rule: a transfer happens on a rising edge with valid&&ready high.
  - Once TxValid is asserted, TxData is held stable and TxValid stays high until accepted.
- IDLE/DONE, Start:
  - Clear ErrorCount, the FirstErr* outputs, Timeout and Done.
  - Load the pattern generator with SeedByte, or 8'h01 if SeedByte==0 and Mode==1.
  - Go to RUN.
  - Start while Busy is ignored.
- RUN transmit:
  - TxValid=1 when sent<NumBytes and outstanding<Depth.
  - On a Tx handshake: push TxData into the expected FIFO, advance the pattern, increment sent.
- Pattern next value:
  - Mode 0: next = cur+1 mod 256.
  - Mode 1: next = {cur[6:0],1'b0} ^ (cur[7] ? 8'h1D : 8'h00).
- RUN/DRAIN receive:
  - RxReady=1 in both states.
  - On an Rx handshake with the FIFO non-empty: pop the FIFO and compare.
  - On a mismatch: increment ErrorCount; if this is the first error, latch the FirstErr* outputs, with the index equal to the received-byte index.
  - On an Rx handshake with the FIFO empty: unexpected byte; ErrorCount+1; nothing is popped; FirstErrExp=8'h00 if this is the first error.
- Simultaneous Tx push and Rx pop in one cycle are both performed; occupancy is unchanged.
  - An Rx pop frees a slot for Tx on the next cycle, not the same cycle.
- RUN→DRAIN when sent==NumBytes.
  - DRAIN→DONE when the FIFO is empty.
  - Going to DONE sets Done=1 and drives Pass.
- Timeout:
  - Counter clears on every Rx handshake, and whenever the FIFO is empty.
  - Otherwise it increments each cycle.
  - At TimeoutCycles-1 it sets Timeout=1; state goes to DONE with Pass=0, and the FIFO is flushed.
- Bytes arriving in DONE/IDLE: RxReady=0; they are not counted.
- Widths:
  - sent counter: 16 bits.
  - outstanding count: $clog2(Depth)+1 bits.
  - timeout counter: $clog2(TimeoutCycles) bits.
- Latency: first TxValid appears the cycle after Start is sampled.

Decomposition:
- Shared package uart_echo_pkg holds:
  - state enum {IDLE, RUN, DRAIN, DONE}
  - MODE_INC=0, MODE_LFSR=1
  - LFSR_TAPS=8'h1D
- One sub-module, echo_expect_fifo: synchronous FIFO, parameters Width=8 and Depth, with push/pop/full/empty/count and a flush input.
  - Simultaneous push and pop are legal when full or empty-with-push.

Test Plan:
1. Mode 0, NumBytes=16, ideal loopback model (TxData registered one cycle into RxData/RxValid) → bytes 8'h7a..8'h89; Done, Pass=1, ErrorCount=0.
2. Same setup, model corrupts byte index 3 to 8'h00 → ErrorCount=1, FirstErrIndex=3, FirstErrGot=8'h00, FirstErrExp=8'h7d, Pass=0.
3. Mode 1, seed 8'h7a, NumBytes=4 → TxData sequence 8'h7a, 8'hf4, 8'hf5, 8'hf7; Pass=1.
4. Depth=4, model withholds echoes → exactly 4 Tx handshakes; after TimeoutCycles, Timeout=1, Done=1, Pass=0.
5. TxReady toggling every other cycle plus RxValid bursts with simultaneous push/pop → TxData stable while stalled; occupancy never exceeds Depth; Pass=1.
6. Reset asserted for 1 cycle at byte 5 of 16 → next cycle all outputs 0 and state IDLE; a new Start rerun passes from 8'h7a.
